// File: rtl/sram_port_arbiter_if.sv
// Request, response and SRAM-side signal bundle for sram_port_arbiter.
// slave: arbiter view; master: view of the surrounding masters and SRAM macro.
interface sram_port_arbiter_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 15
);
  localparam int unsigned STRB_W = DATA_W / 8;

  logic              load;
  logic              b_valid;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_wdata;
  logic [STRB_W-1:0] b_wstrb;
  logic              b_ready;
  logic              d_valid;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [STRB_W-1:0] d_wstrb;
  logic [DATA_W-1:0] d_rdata;
  logic              d_ready;
  logic              i_valid;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_rdata;
  logic              i_ready;
  logic              sram_valid;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_wdata;
  logic [STRB_W-1:0] sram_wstrb;
  logic [DATA_W-1:0] sram_rdata;

  modport slave (
    input  load,
    input  b_valid, b_addr, b_wdata, b_wstrb,
    output b_ready,
    input  d_valid, d_addr, d_wdata, d_wstrb,
    output d_rdata, d_ready,
    input  i_valid, i_addr,
    output i_rdata, i_ready,
    output sram_valid, sram_addr, sram_wdata, sram_wstrb,
    input  sram_rdata
  );

  modport master (
    output load,
    output b_valid, b_addr, b_wdata, b_wstrb,
    input  b_ready,
    output d_valid, d_addr, d_wdata, d_wstrb,
    input  d_rdata, d_ready,
    output i_valid, i_addr,
    input  i_rdata, i_ready,
    input  sram_valid, sram_addr, sram_wdata, sram_wstrb,
    output sram_rdata
  );
endinterface

// File: rtl/sram_port_arbiter.sv
// Shares one single-port SRAM between boot loader, CPU data bus and CPU instruction bus.
// SRAM_ARB_RR_EN: round-robin data/instruction tie-break; otherwise fixed data > instruction.
module sram_port_arbiter #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 15
) (
  input logic                clk,
  input logic                rst,
  sram_port_arbiter_if.slave bus
);
  localparam int unsigned STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
  typedef enum logic [1:0] {G_NONE, G_B, G_D, G_I} grant_t;

  state_t            state_q, state_d;
  grant_t            grant_q, grant_d, pick_c;
  logic              sram_valid_q, sram_valid_d;
  logic [ADDR_W-1:0] sram_addr_q, sram_addr_d;
  logic [DATA_W-1:0] sram_wdata_q, sram_wdata_d;
  logic [STRB_W-1:0] sram_wstrb_q, sram_wstrb_d;
  logic              b_ready_q, b_ready_d;
  logic              d_ready_q, d_ready_d;
  logic              i_ready_q, i_ready_d;
  logic [DATA_W-1:0] d_hold_q, d_hold_d;
  logic [DATA_W-1:0] i_hold_q, i_hold_d;
  logic              d_elig_c, i_elig_c, rd_access_c;

  assign d_elig_c    = bus.d_valid & ~bus.load;
  assign i_elig_c    = bus.i_valid & ~bus.load;
  // Strobes are held through RESP, so they still tell whether the access was a read.
  assign rd_access_c = (sram_wstrb_q == '0);

`ifdef SRAM_ARB_RR_EN
  logic rr_q, rr_d;  // 1: instruction bus wins the next data/instruction tie

  always_comb begin
    pick_c = G_NONE;
    if (bus.b_valid)                pick_c = G_B;
    else if (d_elig_c && i_elig_c)  pick_c = rr_q ? G_I : G_D;
    else if (d_elig_c)              pick_c = G_D;
    else if (i_elig_c)              pick_c = G_I;
  end

  always_comb begin
    rr_d = rr_q;
    if (state_q == IDLE && pick_c == G_D)      rr_d = 1'b1;
    else if (state_q == IDLE && pick_c == G_I) rr_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) rr_q <= 1'b0;
    else     rr_q <= rr_d;
  end
`else
  always_comb begin
    pick_c = G_NONE;
    if (bus.b_valid)   pick_c = G_B;
    else if (d_elig_c) pick_c = G_D;
    else if (i_elig_c) pick_c = G_I;
  end
`endif

  // Next-state and registered-output logic
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    sram_valid_d = 1'b0;
    sram_addr_d  = sram_addr_q;
    sram_wdata_d = sram_wdata_q;
    sram_wstrb_d = sram_wstrb_q;
    b_ready_d    = 1'b0;
    d_ready_d    = 1'b0;
    i_ready_d    = 1'b0;
    d_hold_d     = d_hold_q;
    i_hold_d     = i_hold_q;
    unique case (state_q)
      IDLE: begin
        if (pick_c != G_NONE) begin
          state_d      = ISSUE;
          grant_d      = pick_c;
          sram_valid_d = 1'b1;
          unique case (pick_c)
            G_B: begin
              sram_addr_d  = bus.b_addr;
              sram_wdata_d = bus.b_wdata;
              sram_wstrb_d = bus.b_wstrb;
            end
            G_D: begin
              sram_addr_d  = bus.d_addr;
              sram_wdata_d = bus.d_wdata;
              sram_wstrb_d = bus.d_wstrb;
            end
            G_I: begin
              sram_addr_d  = bus.i_addr;
              sram_wstrb_d = '0;
            end
            default: ;
          endcase
        end
      end
      ISSUE: begin
        state_d   = RESP;
        b_ready_d = (grant_q == G_B);
        d_ready_d = (grant_q == G_D);
        i_ready_d = (grant_q == G_I);
      end
      RESP: begin
        state_d = IDLE;
        grant_d = G_NONE;
        if (grant_q == G_D && rd_access_c) d_hold_d = bus.sram_rdata;
        if (grant_q == G_I)                i_hold_d = bus.sram_rdata;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= G_NONE;
      sram_valid_q <= 1'b0;
      sram_addr_q  <= '0;
      sram_wdata_q <= '0;
      sram_wstrb_q <= '0;
      b_ready_q    <= 1'b0;
      d_ready_q    <= 1'b0;
      i_ready_q    <= 1'b0;
      d_hold_q     <= '0;
      i_hold_q     <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      sram_valid_q <= sram_valid_d;
      sram_addr_q  <= sram_addr_d;
      sram_wdata_q <= sram_wdata_d;
      sram_wstrb_q <= sram_wstrb_d;
      b_ready_q    <= b_ready_d;
      d_ready_q    <= d_ready_d;
      i_ready_q    <= i_ready_d;
      d_hold_q     <= d_hold_d;
      i_hold_q     <= i_hold_d;
    end
  end

  // Read data arrives from the macro during RESP, so it is passed through alongside ready.
  assign bus.d_rdata    = (d_ready_q && rd_access_c) ? bus.sram_rdata : d_hold_q;
  assign bus.i_rdata    = i_ready_q ? bus.sram_rdata : i_hold_q;
  assign bus.b_ready    = b_ready_q;
  assign bus.d_ready    = d_ready_q;
  assign bus.i_ready    = i_ready_q;
  assign bus.sram_valid = sram_valid_q;
  assign bus.sram_addr  = sram_addr_q;
  assign bus.sram_wdata = sram_wdata_q;
  assign bus.sram_wstrb = sram_wstrb_q;
endmodule
